gf180mcu_fd_io__ring_seq: RTL and testbench

GF180MCU_FD_IO__RING_SEQ -- requirements
Module: gf180mcu_fd_io__ring_seq

---
 rtl/gf180mcu_fd_io__ring_seq.sv | 217 +++++++++++++++++++++
 tb/tb_gf180mcu_fd_io__ring_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_io__ring_seq.sv
// IO-ring supply sequencer: brings break-cell-delimited segments up in ascending
// order (input gate, settle, output gate) and down in descending order, with fault latch.
module gf180mcu_fd_io__ring_seq #(
  parameter int NSEG       = 4,
  parameter int SETTLE_CYC = 16,
  parameter int TMO_CYC    = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PWR_REQ,
  input  logic [NSEG-1:0] PGOOD,
  input  logic            FAULT_CLR,
  output logic [NSEG-1:0] SEG_IE,
  output logic [NSEG-1:0] SEG_OE,
  output logic            RDY,
  output logic            FAULT
);

  localparam int              IDXW        = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NSEG - 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]      TMO_LAST    = 8'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_PG,
    S_SETTLE,
    S_ON,
    S_DOWN,
    S_FLT
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NSEG-1:0] ie_q, ie_d;
  logic [NSEG-1:0] oe_q, oe_d;
  logic            rdy_q, rdy_d;
  logic            fault_q, fault_d;

  // One-hot of the current segment; shifted down it selects the segment below.
  logic [NSEG-1:0] idx_oh;
  logic [NSEG-1:0] below_oh;

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_idx_oh
      assign idx_oh[gi] = (idx_q == IDXW'(gi));
    end
  endgenerate

  assign below_oh = idx_oh >> 1;

  logic pg_idx;
  logic pg_drop;
  logic idx_zero;
  logic settle_done;
  logic tmo_hit;

  assign pg_idx      = |(PGOOD & idx_oh);
  assign pg_drop     = |(ie_q & ~PGOOD);
  assign idx_zero    = (idx_q == '0);
  assign settle_done = (cnt_q == SETTLE_LAST);
  assign tmo_hit     = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ie_d    = ie_q;
    oe_d    = oe_q;
    rdy_d   = rdy_q;
    fault_d = fault_q;

    unique case (state_q)
      S_OFF: begin
        ie_d    = '0;
        oe_d    = '0;
        rdy_d   = 1'b0;
        fault_d = 1'b0;
        if (PWR_REQ) begin
          state_d = S_WAIT_PG;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      S_WAIT_PG: begin
        if (pg_drop) begin
          state_d = S_FLT;
        end else if (!PWR_REQ) begin
          // Segments below idx are fully up; tear down from the topmost one.
          cnt_d = '0;
          if (idx_zero) begin
            state_d = S_OFF;
          end else begin
            state_d = S_DOWN;
            ie_d    = ie_q & ~below_oh;
            oe_d    = oe_q & ~below_oh;
            idx_d   = idx_q - 1'b1;
          end
        end else if (pg_idx) begin
          state_d = S_SETTLE;
          ie_d    = ie_q | idx_oh;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = S_FLT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_SETTLE: begin
        if (pg_drop) begin
          state_d = S_FLT;
        end else if (!PWR_REQ) begin
          state_d = S_DOWN;
          ie_d    = ie_q & ~idx_oh;
          oe_d    = oe_q & ~idx_oh;
          cnt_d   = '0;
        end else if (settle_done) begin
          oe_d  = oe_q | idx_oh;
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_ON;
            rdy_d   = 1'b1;
          end else begin
            state_d = S_WAIT_PG;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ON: begin
        if (pg_drop) begin
          state_d = S_FLT;
        end else if (!PWR_REQ) begin
          state_d = S_DOWN;
          rdy_d   = 1'b0;
          ie_d    = ie_q & ~idx_oh;
          oe_d    = oe_q & ~idx_oh;
          cnt_d   = '0;
        end
      end

      S_DOWN: begin
        // idx names the segment cleared most recently.
        if (settle_done) begin
          cnt_d = '0;
          if (idx_zero) begin
            state_d = S_OFF;
          end else begin
            ie_d  = ie_q & ~below_oh;
            oe_d  = oe_q & ~below_oh;
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_FLT: begin
        if (FAULT_CLR && !PWR_REQ) begin
          state_d = S_OFF;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = S_OFF;
        idx_d   = '0;
        cnt_d   = '0;
        ie_d    = '0;
        oe_d    = '0;
        rdy_d   = 1'b0;
        fault_d = 1'b0;
      end
    endcase

    // Fault entry drops every gate at once regardless of the originating state.
    if (state_d == S_FLT && state_q != S_FLT) begin
      idx_d   = '0;
      cnt_d   = '0;
      ie_d    = '0;
      oe_d    = '0;
      rdy_d   = 1'b0;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      ie_q    <= '0;
      oe_q    <= '0;
      rdy_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ie_q    <= ie_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      fault_q <= fault_d;
    end
  end

  assign SEG_IE = ie_q;
  assign SEG_OE = oe_q;
  assign RDY    = rdy_q;
  assign FAULT  = fault_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__ring_seq.sv
// Bench for the IO-ring sequencer: directed timing scenarios plus randomized traffic,
// checked every cycle against a segment-count reference model.
module tb_gf180mcu_fd_io__ring_seq;

  localparam int NSEG = 4;
  localparam int S    = 4;
  localparam int TMO  = 8;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DOWN = 3;
  localparam int M_FLT  = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            PWR_REQ;
  logic [NSEG-1:0] PGOOD;
  logic            FAULT_CLR;
  logic [NSEG-1:0] SEG_IE;
  logic [NSEG-1:0] SEG_OE;
  logic            RDY;
  logic            FAULT;

  gf180mcu_fd_io__ring_seq #(
    .NSEG      (NSEG),
    .SETTLE_CYC(S),
    .TMO_CYC   (TMO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PWR_REQ  (PWR_REQ),
    .PGOOD    (PGOOD),
    .FAULT_CLR(FAULT_CLR),
    .SEG_IE   (SEG_IE),
    .SEG_OE   (SEG_OE),
    .RDY      (RDY),
    .FAULT    (FAULT)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int cur         = 0;
  bit chk_en      = 1'b0;

  // Model: number of segments with input/output gates on, a mode and a timer.
  int m_mode = M_OFF;
  int m_nie  = 0;
  int m_noe  = 0;
  int m_t    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_outs();
    logic [3:0] ie;
    logic [3:0] oe;
    ie = 4'((1 << m_nie) - 1);
    oe = 4'((1 << m_noe) - 1);
    return {ie, oe, (m_mode == M_ON), (m_mode == M_FLT)};
  endfunction

  task automatic model_fault();
    m_mode = M_FLT;
    m_nie  = 0;
    m_noe  = 0;
    m_t    = 0;
  endtask

  task automatic model_step();
    bit drop;
    drop = 1'b0;
    for (int k = 0; k < m_nie; k++) if (!PGOOD[k]) drop = 1'b1;
    if (RST) begin
      m_mode = M_OFF; m_nie = 0; m_noe = 0; m_t = 0;
    end else begin
      case (m_mode)
        M_OFF: if (PWR_REQ) begin m_mode = M_UP; m_t = 0; end
        M_UP: begin
          if (drop) model_fault();
          else if (!PWR_REQ) begin
            if (m_nie == 0) m_mode = M_OFF;
            else begin
              m_nie  = m_nie - 1;
              if (m_noe > m_nie) m_noe = m_nie;
              m_mode = M_DOWN;
              m_t    = 0;
            end
          end else if (m_nie == m_noe) begin
            if (PGOOD[m_nie]) begin m_nie++; m_t = 0; end
            else if (m_t == TMO - 1) model_fault();
            else m_t++;
          end else begin
            if (m_t == S - 1) begin
              m_noe++;
              m_t = 0;
              if (m_noe == NSEG) m_mode = M_ON;
            end else m_t++;
          end
        end
        M_ON: begin
          if (drop) model_fault();
          else if (!PWR_REQ) begin
            m_nie = NSEG - 1; m_noe = NSEG - 1; m_mode = M_DOWN; m_t = 0;
          end
        end
        M_DOWN: begin
          if (m_t == S - 1) begin
            m_t = 0;
            if (m_nie == 0) m_mode = M_OFF;
            else begin m_nie = m_nie - 1; m_noe = m_nie; end
          end else m_t++;
        end
        M_FLT: if (FAULT_CLR && !PWR_REQ) m_mode = M_OFF;
        default: m_mode = M_OFF;
      endcase
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
      cur++;
    end
  endtask

  task automatic goto(input int c);
    if (c > cur) step(c - cur);
  endtask

  task automatic do_reset();
    RST = 1'b1; PWR_REQ = 1'b0; FAULT_CLR = 1'b0; PGOOD = 4'hF;
    step(2);
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [4:0] ie_inc;
      ie_inc = {1'b0, SEG_IE} + 5'd1;
      check("outputs_vs_model", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, {22'd0, model_outs()});
      check("oe_implies_ie", {28'd0, SEG_OE & ~SEG_IE}, 32'd0);
      check("ie_contiguous", {27'd0, ie_inc & {1'b0, SEG_IE}}, 32'd0);
    end
  end

  initial begin
    RST = 1'b1; PWR_REQ = 1'b1; FAULT_CLR = 1'b1; PGOOD = 4'h0;
    @(posedge CLK);
    model_step();
    #1;
    chk_en = 1'b1;
    check("reset_outputs", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, 32'd0);
    step(1);
    check("reset_hold", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, 32'd0);

    // Power-up and power-down timing with all supplies good.
    do_reset();
    PWR_REQ = 1'b1; cur = 0;
    goto(1);  check("up_ie_c1", {28'd0, SEG_IE}, 32'h0);
    goto(2);  check("up_ie_c2", {28'd0, SEG_IE}, 32'h1);
    goto(5);  check("up_oe_c5", {28'd0, SEG_OE}, 32'h0);
    goto(6);  check("up_oe_c6", {28'd0, SEG_OE}, 32'h1);
    goto(16); check("up_ie_c16", {28'd0, SEG_IE}, 32'h7);
    goto(17); check("up_ie_c17", {28'd0, SEG_IE}, 32'hF);
    goto(20); check("up_rdy_c20", {31'd0, RDY}, 32'd0);
    goto(21); check("up_rdy_c21", {27'd0, SEG_OE, RDY}, 32'h1F);
    goto(25); PWR_REQ = 1'b0;
    goto(26); check("dn_t1", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, {22'd0, 4'h7, 4'h7, 2'b00});
    goto(29); check("dn_t4", {28'd0, SEG_IE}, 32'h7);
    goto(30); check("dn_t5", {28'd0, SEG_IE}, 32'h3);
    goto(34); check("dn_t9", {28'd0, SEG_IE}, 32'h1);
    goto(38); check("dn_t13", {24'd0, SEG_IE, SEG_OE}, 32'h0);
    goto(41); PWR_REQ = 1'b1;
    goto(43); check("reup_t18", {28'd0, SEG_IE}, 32'h0);
    goto(44); check("reup_t19", {28'd0, SEG_IE}, 32'h1);

    // Timeout with no supply good, then fault-clear handling.
    do_reset();
    PGOOD = 4'h0; PWR_REQ = 1'b1; cur = 0;
    goto(8); check("tmo_c8", {31'd0, FAULT}, 32'd0);
    goto(9); check("tmo_c9", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, 32'h1);
    FAULT_CLR = 1'b1;
    goto(10); FAULT_CLR = 1'b0;
    check("clr_ignored", {31'd0, FAULT}, 32'd1);
    PWR_REQ = 1'b0; FAULT_CLR = 1'b1;
    goto(11); FAULT_CLR = 1'b0; PGOOD = 4'hF;
    check("clr_taken", {31'd0, FAULT}, 32'd0);

    // Supply drop and power-down request in the same cycle while on.
    do_reset();
    PWR_REQ = 1'b1; cur = 0;
    goto(22); check("on_rdy", {31'd0, RDY}, 32'd1);
    PGOOD = 4'b1101; PWR_REQ = 1'b0;
    goto(23); check("drop_prio", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, 32'h1);
    FAULT_CLR = 1'b1;
    goto(24); FAULT_CLR = 1'b0; PGOOD = 4'hF;

    // Reset pulse during settle of segment 2, then restart from segment 0.
    do_reset();
    PWR_REQ = 1'b1; cur = 0;
    goto(12); check("settle2_state", {24'd0, SEG_IE, SEG_OE}, {24'd0, 4'h7, 4'h3});
    goto(13); RST = 1'b1;
    goto(14); RST = 1'b0;
    check("rst_mid", {22'd0, SEG_IE, SEG_OE, RDY, FAULT}, 32'h0);
    goto(15); check("restart_c15", {28'd0, SEG_IE}, 32'h0);
    goto(16); check("restart_c16", {28'd0, SEG_IE}, 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) PWR_REQ = ~PWR_REQ;
      if ($urandom_range(29) == 0) PGOOD = ($urandom_range(9) < 7) ? 4'hF : 4'($urandom);
      FAULT_CLR = ($urandom_range(9) == 0);
      RST = ($urandom_range(299) == 0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
